// File: rtl/seq_det_cnt_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_cnt_pkg
// Shared definitions for the 1,1,0,1 serial sequence detector slice:
//   - state_t      : detector states, encoded as the matched-prefix length
//   - PATTERN      : detected pattern, bit 0 is the earliest bit in time
//   - FRAME_FIRST  : BIT_SEL value of the first bit of an 8-bit frame
//   - FRAME_LAST   : BIT_SEL value of the last bit of an 8-bit frame
//   - is_onehot()  : BIT_SEL qualification helper
// -----------------------------------------------------------------------------
package seq_det_cnt_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_1    = 2'd1,
    S_11   = 2'd2,
    S_110  = 2'd3
  } state_t;

  // Time order 1,1,0,1: PATTERN[n] is the bit expected after n matched bits.
  localparam logic [3:0] PATTERN     = 4'b1011;
  localparam logic [7:0] FRAME_FIRST = 8'h01;
  localparam logic [7:0] FRAME_LAST  = 8'h80;

  function automatic logic is_onehot(input logic [7:0] v);
    return (v != 8'h00) && ((v & (v - 8'd1)) == 8'h00);
  endfunction

endpackage

// File: rtl/seq_det_cnt_if.sv
// -----------------------------------------------------------------------------
// seq_det_cnt_if
// Bundle between the upstream switch sequence driver and the detector.
//   X, BIT_SEL          : serial bit and its one-hot frame position (driver)
//   Z                   : registered 1-cycle match pulse
//   COUNT               : saturating running match total (CNT_W bits)
//   FRAME_CNT/FRAME_VLD : matches in the last completed frame / update pulse
//   ERR                 : sticky "BIT_SEL was not one-hot"
//   dbg_state           : current detector state, for observation only
// modport master : driver side; modport slave : detector side.
//
// Qualification: there is no ready; the detector accepts X every CLK. A cycle
// is valid only when BIT_SEL is one-hot. An invalid cycle is ignored by the
// detector/counters/framing and only raises ERR.
// -----------------------------------------------------------------------------
interface seq_det_cnt_if
  import seq_det_cnt_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int FRM_W = 4
);
  logic             X;
  logic [7:0]       BIT_SEL;
  logic             Z;
  logic [CNT_W-1:0] COUNT;
  logic [FRM_W-1:0] FRAME_CNT;
  logic             FRAME_VLD;
  logic             ERR;
  state_t           dbg_state;

  modport master (
    output X, BIT_SEL,
    input  Z, COUNT, FRAME_CNT, FRAME_VLD, ERR, dbg_state
  );

  modport slave (
    input  X, BIT_SEL,
    output Z, COUNT, FRAME_CNT, FRAME_VLD, ERR, dbg_state
  );
endinterface

// File: rtl/seq_det_cnt_fsm_1101.sv
// -----------------------------------------------------------------------------
// seq_fsm_1101
// Overlapping 1,1,0,1 detector FSM.
//   CLK, RST : clock, asynchronous active-high reset
//   x        : serial bit
//   valid    : cycle qualifier; the FSM holds when low
//   resync   : evaluate this cycle as if from S_IDLE
//   match    : combinational Mealy match (S_110 and x==1 on a valid cycle)
//   state    : current state register, for observation
// -----------------------------------------------------------------------------
module seq_fsm_1101
  import seq_det_cnt_pkg::*;
(
  input  logic   CLK,
  input  logic   RST,
  input  logic   x,
  input  logic   valid,
  input  logic   resync,
  output logic   match,
  output state_t state
);

  state_t state_q, state_d, cur;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    cur     = resync ? S_IDLE : state_q;
    state_d = state_q;
    match   = 1'b0;
    if (valid) begin
      case (cur)
        S_IDLE: state_d = (x == PATTERN[0]) ? S_1 : S_IDLE;
        S_1:    state_d = (x == PATTERN[1]) ? S_11 : S_IDLE;
        // A 1 while waiting for the 0 keeps the last two 1s as a prefix.
        S_11:   state_d = (x == PATTERN[2]) ? S_110 : S_11;
        S_110: begin
          if (x == PATTERN[3]) begin
            match   = 1'b1;
            state_d = S_1;  // the final 1 starts the next pattern
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: rtl/seq_det_cnt.sv
// -----------------------------------------------------------------------------
// seq_det_cnt
// Serial 1,1,0,1 detector with saturating match counter and per-frame count.
// Ports:
//   CLK, RST : clock (rising edge), asynchronous active-high reset
//   bus      : seq_det_cnt_if.slave (X, BIT_SEL in; Z, COUNT, FRAME_CNT,
//              FRAME_VLD, ERR, dbg_state out)
// Parameters: CNT_W (COUNT width), FRM_W (FRAME_CNT width); must match the
// connected interface instance.
// Build option: FRAME_RESYNC_EN -- when defined, the first bit of each frame
// (BIT_SEL==8'h01) is evaluated from S_IDLE so matches never straddle frames.
// -----------------------------------------------------------------------------
module seq_det_cnt
  import seq_det_cnt_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int FRM_W = 4
)(
  input  logic          CLK,
  input  logic          RST,
  seq_det_cnt_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [FRM_W-1:0] ACC_MAX = {FRM_W{1'b1}};

  logic             valid;
  logic             frame_last;
  logic             resync;
  logic             match;
  state_t           state;
  logic [CNT_W-1:0] count_q;
  logic [FRM_W-1:0] acc_q, acc_inc, frame_cnt_q;
  logic             z_q, frame_vld_q, err_q;

  assign valid      = is_onehot(bus.BIT_SEL);
  assign frame_last = valid && (bus.BIT_SEL == FRAME_LAST);

`ifdef FRAME_RESYNC_EN
  assign resync = valid && (bus.BIT_SEL == FRAME_FIRST);
`else
  assign resync = 1'b0;
`endif

  seq_fsm_1101 u_fsm (
    .CLK    (CLK),
    .RST    (RST),
    .x      (bus.X),
    .valid  (valid),
    .resync (resync),
    .match  (match),
    .state  (state)
  );

  // Accumulator including this cycle's match, so a match on bit 7 lands in
  // the frame being closed.
  assign acc_inc = (match && (acc_q != ACC_MAX)) ? acc_q + 1'b1 : acc_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      z_q         <= 1'b0;
      count_q     <= '0;
      acc_q       <= '0;
      frame_cnt_q <= '0;
      frame_vld_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      z_q         <= match;       // match is already gated by valid
      frame_vld_q <= frame_last;
      if (!valid) err_q <= 1'b1;
      if (match && (count_q != CNT_MAX)) count_q <= count_q + 1'b1;
      if (frame_last) begin
        frame_cnt_q <= acc_inc;
        acc_q       <= '0;
      end else if (valid) begin
        acc_q       <= acc_inc;
      end
    end
  end

  assign bus.Z         = z_q;
  assign bus.COUNT     = count_q;
  assign bus.FRAME_CNT = frame_cnt_q;
  assign bus.FRAME_VLD = frame_vld_q;
  assign bus.ERR       = err_q;
  assign bus.dbg_state = state;

endmodule
